mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a grant waits for mem_ready before abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  fetch request from core; held until i_ack.
REQ-005 i_addr  input  32  fetch address (core ia).
REQ-006 i_data  output  32  fetched instruction (core id); registered.
REQ-007 i_ack  output  1  one-cycle pulse: fetch complete.
REQ-008 d_rd  input  1  data read request (core MemRead); held until d_ack.
REQ-009 d_wr  input  1  data write request (core MemWrite); held until d_ack.
REQ-010 d_addr  input  32  data address (core memAddr).
REQ-011 d_wdata  input  32  store data (core memWriteData).
REQ-012 d_rdata  output  32  load data (core memReadData); registered.
REQ-013 d_ack  output  1  one-cycle pulse: data access complete.
REQ-014 stall  output  1  core must hold PC and register writes.
REQ-015 err  output  1  one-cycle pulse: timeout or illegal request.
REQ-016 mem_req  output  1  request to the single shared memory port.
REQ-017 mem_we  output  1  write enable for current memory request.
REQ-018 mem_addr  output  32  memory address.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-021 mem_ready  input  1  memory completes current request this cycle.

Function
REQ-022 FSM states SHALL be IDLE, FETCH, DATA.
REQ-023 IDLE: if d_rd|d_wr -> DATA; else if i_req -> FETCH; else stay; data has fixed priority over fetch.
REQ-024 On entry to FETCH/DATA, mem_addr/mem_we/mem_wdata SHALL be latched from core inputs and held constant until exit.
REQ-025 mem_req SHALL be 1 exactly while in FETCH or DATA; mem_we SHALL be 1 only in DATA for a write.
REQ-026 FETCH/DATA with mem_ready=1 -> IDLE; mem_rdata captured into i_data (FETCH) or d_rdata (DATA read) on that edge.
REQ-027 i_ack/d_ack SHALL pulse the cycle after the mem_ready cycle; minimum latency request-to-ack = 2 cycles.
REQ-028 i_data and d_rdata SHALL hold their value until the next capture; a data write SHALL not alter d_rdata.
REQ-029 stall = (i_req & ~i_ack) | ((d_rd|d_wr) & ~d_ack), combinational.
REQ-030 A wait counter SHALL clear on entry to FETCH/DATA and increment each cycle without mem_ready.
REQ-031 Counter reaching TIMEOUT-1 without mem_ready: return to IDLE, pulse err, pulse the pending ack, leave captured data unchanged.
REQ-032 d_rd & d_wr both 1: treat as write, pulse err on the grant cycle.
REQ-033 mem_ready while IDLE SHALL be ignored.
REQ-034 Requests deasserted mid-grant SHALL not abort the memory transaction; ack still pulses.
REQ-035 Back-to-back: IDLE re-arbitrates the cycle after the ack; no idle gap beyond that cycle.

Reset
REQ-036 reset asynchronously forces IDLE, counter=0, mem_req=0, mem_we=0, i_ack=0, d_ack=0, err=0, i_data=0, d_rdata=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset mid-grant SHALL drop mem_req immediately; no ack for the aborted request after reset release.

Structure
REQ-038 State enum and default TIMEOUT SHALL live in shared package beta_pkg.
REQ-039 Wait counter SHALL be sub-module wait_timer (clear, enable, expired output).

Verification
REQ-040 i_req=1, i_addr=0x10, mem_ready on 1st grant cycle, mem_rdata=0x20220005 -> mem_req 1 cycle, i_ack at +2, i_data=0x20220005, stall low after ack.
REQ-041 i_req and d_rd together, d_addr=0x100 -> DATA served first (mem_addr=0x100), d_ack, then FETCH, i_ack.
REQ-042 d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1, values stable 4 cycles, d_ack, d_rdata unchanged.
REQ-043 i_req with mem_ready never asserted, TIMEOUT=16 -> err and i_ack pulse 16 cycles after grant, state IDLE.
REQ-044 reset asserted during DATA wait -> mem_req=0 same cycle, all outputs at reset values, no ack after release.
REQ-045 d_rd=d_wr=1 -> write issued, err pulses once.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package beta_pkg;

  // Default number of grant cycles allowed before a stalled access is abandoned.
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // Arbiter states: idle, serving an instruction fetch, serving a data access.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StData  = 2'd2
  } arb_state_e;

  // Width of a counter that has to reach timeout-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signal bundle of the arbiter.
// master: the arbiter's view. slave: the environment (core plus memory).
interface mem_arbiter_if;

  // Instruction fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack;

  // Data port
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  // Core status
  logic        stall;
  logic        err;

  // Shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_data, i_ack, d_rdata, d_ack, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_data, i_ack, d_rdata, d_ack, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/wait_timer.sv
// Grant wait counter: cleared while idle, counts cycles the memory has not
// answered, and flags when the last allowed cycle has been reached.
module wait_timer
  import beta_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LastCount = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, then saturating increment at the last cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCount);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access.
// Data has fixed priority; each grant latches its request and holds it on the
// memory port until the memory answers or the wait timer runs out.
module mem_arbiter
  import beta_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        we_q, we_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;

  logic busy;
  logic d_any;
  logic ack_hold;
  logic expired;

  assign busy  = (state_q != StIdle);
  assign d_any = bus.d_rd | bus.d_wr;
  // During the ack cycle the core still presents the request it is being
  // acked for, so arbitration waits one cycle to avoid re-serving it.
  assign ack_hold = i_ack_q | d_ack_q;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy),
    .enable  (busy & ~bus.mem_ready),
    .expired (expired)
  );

  // Next-state, request latching, capture and single-cycle strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!ack_hold) begin
          if (d_any) begin
            state_d = StData;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            // Read and write together is resolved as a write and flagged.
            we_d    = bus.d_wr;
            err_d   = bus.d_rd & bus.d_wr;
          end else if (bus.i_req) begin
            state_d = StFetch;
            addr_d  = bus.i_addr;
            we_d    = 1'b0;
          end
        end
      end

      StFetch: begin
        if (bus.mem_ready) begin
          state_d  = StIdle;
          i_data_d = bus.mem_rdata;
          i_ack_d  = 1'b1;
        end else if (expired) begin
          // Abandon: ack so the core can move on, keep old fetch data.
          state_d = StIdle;
          i_ack_d = 1'b1;
          err_d   = 1'b1;
        end
      end

      StData: begin
        if (bus.mem_ready) begin
          state_d = StIdle;
          we_d    = 1'b0;
          d_ack_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else if (expired) begin
          state_d = StIdle;
          we_d    = 1'b0;
          d_ack_d = 1'b1;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  // mem_req follows the state directly so reset drops it immediately.
  assign bus.mem_req   = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_data    = i_data_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.i_req & ~i_ack_q) | (d_any & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory
// transactions and expected ack/err events; a memory responder and an event
// monitor pop and compare independently of the stimulus.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;    // ready on this grant cycle index; negative = never
  } mem_item_t;

  typedef struct {
    logic        ia;
    logic        da;
    logic        er;
    logic [31:0] idata;
    logic [31:0] drdata;
  } ev_t;

  logic clk;
  logic reset;
  logic idle_ready;

  mem_item_t mem_q[$];
  ev_t       exp_q[$];

  logic [31:0] exp_i_data;
  logic [31:0] exp_d_rdata;

  int n_checks;
  int n_pass;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drop_reqs();
    bus.i_req = 1'b0;
    bus.d_rd  = 1'b0;
    bus.d_wr  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " mem_req"},   32'(bus.mem_req), 32'h0);
    check({tag, " mem_we"},    32'(bus.mem_we),  32'h0);
    check({tag, " i_ack"},     32'(bus.i_ack),   32'h0);
    check({tag, " d_ack"},     32'(bus.d_ack),   32'h0);
    check({tag, " err"},       32'(bus.err),     32'h0);
    check({tag, " i_data"},    bus.i_data,       32'h0);
    check({tag, " d_rdata"},   bus.d_rdata,      32'h0);
    check({tag, " mem_addr"},  bus.mem_addr,     32'h0);
    check({tag, " mem_wdata"}, bus.mem_wdata,    32'h0);
  endtask

  // Count posedges until the wanted ack is seen at a negedge (bounded).
  task automatic wait_ack(input string name, input bit want_i, input bit drop_all,
                          input bit drop_d, output int cyc);
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(posedge clk);
      if (cyc == 0) begin
        #1;
        if (drop_all) drop_reqs();
        if (drop_d) begin
          bus.d_rd = 1'b0;
          bus.d_wr = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
      got = want_i ? bus.i_ack : bus.d_ack;
    end
    if (!got) check({name, " ack_seen"}, 32'(got), 32'h1);
  endtask

  task automatic do_req(input string name, input bit fetch, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat, input bit drop_early);
    mem_item_t m;
    ev_t       e;
    int        cyc;
    m.addr  = addr;
    m.we    = fetch ? 1'b0 : wr;
    m.wdata = wdata;
    m.rdata = rdata;
    m.lat   = lat;
    mem_q.push_back(m);
    if (!fetch && rd && wr) begin
      e = '{ia: 1'b0, da: 1'b0, er: 1'b1, idata: exp_i_data, drdata: exp_d_rdata};
      exp_q.push_back(e);
    end
    if (lat >= 0) begin
      if (fetch) exp_i_data = rdata;
      else if (rd && !wr) exp_d_rdata = rdata;
    end
    e = '{ia: fetch, da: !fetch, er: (lat < 0), idata: exp_i_data, drdata: exp_d_rdata};
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (fetch) begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end else begin
      bus.d_rd    = rd;
      bus.d_wr    = wr;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
    #1 check({name, " stall_while_pending"}, 32'(bus.stall), 32'h1);

    wait_ack(name, fetch, drop_early, 1'b0, cyc);
    check({name, " latency"}, 32'(cyc), (lat < 0) ? 32'(1 + TIMEOUT) : 32'(2 + lat));
    check({name, " idle_at_ack"}, 32'(bus.mem_req), 32'h0);
    @(posedge clk);
    #1 drop_reqs();
    @(negedge clk);
    check({name, " stall_after_ack"}, 32'(bus.stall), 32'h0);
  endtask

  // Memory model: checks each grant's request and its stability, answers per item.
  initial begin : responder
    mem_item_t cur;
    int        wait_cnt;
    wait_cnt = 0;
    cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, rdata: 32'h0, lat: -1};
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected_req", 32'(bus.mem_req), 32'h0);
            cur = '{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata,
                    rdata: 32'h0, lat: -1};
          end else begin
            cur = mem_q.pop_front();
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_we", 32'(bus.mem_we), 32'(cur.we));
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
            else cur.wdata = bus.mem_wdata;
          end
        end else begin
          check("mem_addr_stable", bus.mem_addr, cur.addr);
          check("mem_we_stable", 32'(bus.mem_we), 32'(cur.we));
          check("mem_wdata_stable", bus.mem_wdata, cur.wdata);
        end
        bus.mem_ready = (cur.lat >= 0) && (wait_cnt == cur.lat);
        bus.mem_rdata = cur.rdata;
        wait_cnt++;
      end else begin
        wait_cnt      = 0;
        bus.mem_ready = idle_ready;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Event monitor: every ack/err strobe must match the next expected event.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.i_ack || bus.d_ack || bus.err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {29'b0, bus.i_ack, bus.d_ack, bus.err}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("ev_i_ack", 32'(bus.i_ack), 32'(e.ia));
          check("ev_d_ack", 32'(bus.d_ack), 32'(e.da));
          check("ev_err", 32'(bus.err), 32'(e.er));
          check("ev_i_data", bus.i_data, e.idata);
          check("ev_d_rdata", bus.d_rdata, e.drdata);
        end
      end
    end
  end

  initial begin : stimulus
    mem_item_t m;
    ev_t       e;
    int        cyc;
    n_checks    = 0;
    n_pass      = 0;
    exp_i_data  = 32'h0;
    exp_d_rdata = 32'h0;
    idle_ready  = 1'b0;
    reset       = 1'b1;
    drop_reqs();
    bus.i_addr    = 32'h0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Single fetch answered on the first grant cycle.
    do_req("fetch_basic", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h2022_0005, 0, 1'b0);

    // Data and fetch together: data first, fetch re-arbitrated after the ack.
    m = '{addr: 32'h100, we: 1'b0, wdata: 32'h0, rdata: 32'h1111_2222, lat: 0};
    mem_q.push_back(m);
    m = '{addr: 32'h300, we: 1'b0, wdata: 32'h0, rdata: 32'h3333_4444, lat: 0};
    mem_q.push_back(m);
    exp_d_rdata = 32'h1111_2222;
    e = '{ia: 1'b0, da: 1'b1, er: 1'b0, idata: exp_i_data, drdata: exp_d_rdata};
    exp_q.push_back(e);
    exp_i_data = 32'h3333_4444;
    e = '{ia: 1'b1, da: 1'b0, er: 1'b0, idata: exp_i_data, drdata: exp_d_rdata};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h300;
    bus.d_rd   = 1'b1;
    bus.d_addr = 32'h100;
    wait_ack("prio_data", 1'b0, 1'b0, 1'b0, cyc);
    check("prio_data latency", 32'(cyc), 32'd2);
    wait_ack("prio_fetch", 1'b1, 1'b0, 1'b1, cyc);
    check("prio_fetch gap", 32'(cyc), 32'd3);
    @(posedge clk);
    #1 drop_reqs();

    // Write with three wait cycles; read data must be untouched.
    do_req("write_wait", 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b0);

    // mem_ready pulses while idle must be ignored.
    @(posedge clk);
    #1 idle_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 idle_ready = 1'b0;

    do_req("read_wait1", 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    do_req("fetch_timeout", 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h9999_9999, -1, 1'b0);
    do_req("rd_and_wr", 1'b0, 1'b1, 1'b1, 32'h600, 32'h0BAD_CAFE, 32'h7777_7777, 0, 1'b0);
    do_req("fetch_dropped", 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h55AA_55AA, 3, 1'b1);

    // Reset in the middle of a data wait.
    m = '{addr: 32'h700, we: 1'b0, wdata: 32'h0, rdata: 32'h0, lat: -1};
    mem_q.push_back(m);
    @(posedge clk);
    #1;
    bus.d_rd   = 1'b1;
    bus.d_addr = 32'h700;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    exp_i_data  = 32'h0;
    exp_d_rdata = 32'h0;
    drop_reqs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset mem_req", 32'(bus.mem_req), 32'h0);

    do_req("fetch_after_reset", 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h1357_9BDF, 2, 1'b0);

    repeat (4) @(posedge clk);
    check("exp_q drained", 32'(exp_q.size()), 32'h0);
    check("mem_q drained", 32'(mem_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
